// File: rtl/gelato_warp_ctrl.sv
// gelato_warp_ctrl
// Per-warp lifecycle controller for the Gelato frontend. Each warp moves
// through IDLE -> READY -> INFLIGHT -> {READY, BRWAIT, BARRIER, IDLE}.
// BRWAIT returns to READY on branch resolve. BARRIER returns to READY on
// a CTA-wide release. Only READY warps are fetch-eligible, so a warp has
// at most one fetch outstanding.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rdy               global enable; low freezes all state, inputs ignored
//   launch_valid/warp dispatcher start request; launch_ready is the
//                     combinational accept (rdy && warp IDLE)
//   grant_valid/warp  fetch scheduler issued a PC for a warp
//   dec_valid/warp/kind  decoded instruction kind
//                     (0 normal, 1 branch, 2 barrier, 3 exit)
//   br_valid/warp     branch unit resolved a warp's branch
//   fetch_eligible    bit i set when warp i is READY
//   active_cnt        number of non-IDLE warps
//   all_idle          active_cnt == 0
//   err               sticky protocol-violation flag
module gelato_warp_ctrl #(
  parameter int unsigned WARP_NUM   = 32,
  parameter int unsigned WARP_NUM_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  launch_valid,
  input  logic [WARP_NUM_W-1:0] launch_warp,
  output logic                  launch_ready,
  input  logic                  grant_valid,
  input  logic [WARP_NUM_W-1:0] grant_warp,
  input  logic                  dec_valid,
  input  logic [WARP_NUM_W-1:0] dec_warp,
  input  logic [1:0]            dec_kind,
  input  logic                  br_valid,
  input  logic [WARP_NUM_W-1:0] br_warp,
  output logic [WARP_NUM-1:0]   fetch_eligible,
  output logic [WARP_NUM_W:0]   active_cnt,
  output logic                  all_idle,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READY    = 3'd1,
    INFLIGHT = 3'd2,
    BRWAIT   = 3'd3,
    BARRIER  = 3'd4
  } warp_state_e;

  typedef enum logic [1:0] {
    KIND_NORMAL  = 2'd0,
    KIND_BRANCH  = 2'd1,
    KIND_BARRIER = 2'd2,
    KIND_EXIT    = 2'd3
  } dec_kind_e;

  localparam logic [WARP_NUM_W:0] CNT_ONE = {{WARP_NUM_W{1'b0}}, 1'b1};

  warp_state_e state_q   [WARP_NUM];
  warp_state_e state_nxt [WARP_NUM];

  logic                release_pend_q;
  logic                release_cond;
  logic                err_set;
  logic [WARP_NUM_W:0] barrier_cnt;

  // Population counts and eligibility mask come from registered state only.
  always_comb begin
    active_cnt     = '0;
    barrier_cnt    = '0;
    fetch_eligible = '0;
    for (int unsigned i = 0; i < WARP_NUM; i++) begin
      if (state_q[i] != IDLE)    active_cnt  = active_cnt + CNT_ONE;
      if (state_q[i] == BARRIER) barrier_cnt = barrier_cnt + CNT_ONE;
      fetch_eligible[i] = (state_q[i] == READY);
    end
  end

  assign all_idle     = (active_cnt == '0);
  assign launch_ready = rdy && (state_q[launch_warp] == IDLE);

  // Every warp still alive is parked at the barrier.
  assign release_cond = (active_cnt != '0) && (barrier_cnt == active_cnt) &&
                        (barrier_cnt != '0);

  // Each channel's legality is tested against registered state, and the
  // legal source state of every channel is distinct (IDLE, READY, INFLIGHT,
  // BRWAIT). So when several channels hit one warp, at most one is legal and
  // only that one writes the entry. Release only touches BARRIER warps, which
  // no channel can legally target.
  always_comb begin
    state_nxt = state_q;
    err_set   = 1'b0;

    if (release_pend_q) begin
      for (int unsigned i = 0; i < WARP_NUM; i++) begin
        if (state_q[i] == BARRIER) state_nxt[i] = READY;
      end
    end

    if (launch_valid) begin
      if (state_q[launch_warp] == IDLE) state_nxt[launch_warp] = READY;
      else                              err_set = 1'b1;
    end

    if (grant_valid) begin
      if (state_q[grant_warp] == READY) state_nxt[grant_warp] = INFLIGHT;
      else                              err_set = 1'b1;
    end

    if (dec_valid) begin
      if (state_q[dec_warp] == INFLIGHT) begin
        unique case (dec_kind_e'(dec_kind))
          KIND_NORMAL:  state_nxt[dec_warp] = READY;
          KIND_BRANCH:  state_nxt[dec_warp] = BRWAIT;
          KIND_BARRIER: state_nxt[dec_warp] = BARRIER;
          KIND_EXIT:    state_nxt[dec_warp] = IDLE;
          default:      state_nxt[dec_warp] = state_q[dec_warp];
        endcase
      end else begin
        err_set = 1'b1;
      end
    end

    if (br_valid) begin
      if (state_q[br_warp] == BRWAIT) state_nxt[br_warp] = READY;
      else                            err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WARP_NUM; i++) state_q[i] <= IDLE;
      release_pend_q <= 1'b0;
      err            <= 1'b0;
    end else if (rdy) begin
      state_q <= state_nxt;
      // A release pulse lasts exactly one cycle. Without the clear, the
      // still-registered BARRIER warps would re-arm it on the firing edge.
      release_pend_q <= release_pend_q ? 1'b0 : release_cond;
      err            <= err | err_set;
    end
  end

endmodule

// File: tb/tb_gelato_warp_ctrl.sv
// Directed self-checking bench for gelato_warp_ctrl. Inputs are driven 1ns
// after the rising edge. Outputs are sampled 1ns after the edge.
module tb_gelato_warp_ctrl;

  localparam int unsigned WN  = 32;
  localparam int unsigned WNW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rdy;
  logic           launch_valid;
  logic [WNW-1:0] launch_warp;
  logic           launch_ready;
  logic           grant_valid;
  logic [WNW-1:0] grant_warp;
  logic           dec_valid;
  logic [WNW-1:0] dec_warp;
  logic [1:0]     dec_kind;
  logic           br_valid;
  logic [WNW-1:0] br_warp;
  logic [WN-1:0]  fetch_eligible;
  logic [WNW:0]   active_cnt;
  logic           all_idle;
  logic           err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gelato_warp_ctrl #(.WARP_NUM(WN), .WARP_NUM_W(WNW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .launch_valid   (launch_valid),
    .launch_warp    (launch_warp),
    .launch_ready   (launch_ready),
    .grant_valid    (grant_valid),
    .grant_warp     (grant_warp),
    .dec_valid      (dec_valid),
    .dec_warp       (dec_warp),
    .dec_kind       (dec_kind),
    .br_valid       (br_valid),
    .br_warp        (br_warp),
    .fetch_eligible (fetch_eligible),
    .active_cnt     (active_cnt),
    .all_idle       (all_idle),
    .err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    launch_valid = 1'b0; grant_valid = 1'b0; dec_valid = 1'b0; br_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic launch(input int w);
    launch_valid = 1'b1; launch_warp = WNW'(w);
  endtask

  task automatic grant(input int w);
    grant_valid = 1'b1; grant_warp = WNW'(w);
  endtask

  task automatic dec(input int w, input int k);
    dec_valid = 1'b1; dec_warp = WNW'(w); dec_kind = 2'(k);
  endtask

  // Warps 0,1 to BARRIER, warp 2 left INFLIGHT (all three start READY).
  task automatic park_two();
    grant(0); step();
    dec(0, 2); grant(1); step();
    dec(1, 2); grant(2); step();
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b0; clr();
    launch_warp = '0; grant_warp = '0; dec_warp = '0; dec_kind = '0; br_warp = '0;
    #22;
    chk("rst_elig", 64'(fetch_eligible), 64'h0);
    chk("rst_active", 64'(active_cnt), 64'd0);
    chk("rst_all_idle", 64'(all_idle), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;

    // Launch and grant warp 3
    launch(3); #1;
    chk("launch_ready_idle", 64'(launch_ready), 64'd1);
    step();
    chk("launch3_elig", 64'(fetch_eligible), 64'h8);
    chk("launch3_active", 64'(active_cnt), 64'd1);
    grant(3); step();
    chk("grant3_elig", 64'(fetch_eligible), 64'h0);
    chk("grant3_active", 64'(active_cnt), 64'd1);
    chk("grant3_err", 64'(err), 64'd0);

    // Branch wait then resolve
    dec(3, 1); step();
    chk("brwait_elig0", 64'(fetch_eligible), 64'h0);
    step();
    chk("brwait_elig1", 64'(fetch_eligible), 64'h0);
    br_valid = 1'b1; br_warp = 5'd3; step();
    chk("br_resolved_elig", 64'(fetch_eligible), 64'h8);
    chk("br_err", 64'(err), 64'd0);

    // Exit warp 3
    grant(3); step();
    dec(3, 3); step();
    chk("exit3_active", 64'(active_cnt), 64'd0);
    chk("exit3_all_idle", 64'(all_idle), 64'd1);

    // Barrier with warp 2 arriving last at edge N
    launch(0); step(); launch(1); step(); launch(2); step();
    chk("launch012_elig", 64'(fetch_eligible), 64'h7);
    chk("launch012_active", 64'(active_cnt), 64'd3);
    park_two();
    chk("park_elig", 64'(fetch_eligible), 64'h0);
    dec(2, 2); step();
    chk("bar_N_elig", 64'(fetch_eligible), 64'h0);
    step();
    chk("bar_N1_elig", 64'(fetch_eligible), 64'h0);
    step();
    chk("bar_N2_elig", 64'(fetch_eligible), 64'h7);
    chk("bar_err", 64'(err), 64'd0);

    // Exit of last non-barrier warp releases the barrier
    park_two();
    dec(2, 3); step();
    chk("exit_rel_active", 64'(active_cnt), 64'd2);
    chk("exit_rel_elig0", 64'(fetch_eligible), 64'h0);
    step();
    chk("exit_rel_elig1", 64'(fetch_eligible), 64'h0);
    step();
    chk("exit_rel_elig2", 64'(fetch_eligible), 64'h3);
    launch_warp = 5'd2; #1;
    chk("warp2_idle", 64'(launch_ready), 64'd1);
    launch_warp = 5'd0; #1;
    chk("warp0_busy", 64'(launch_ready), 64'd0);
    chk("exit_rel_err", 64'(err), 64'd0);

    // Illegal grant on warp 5, launch+dec on idle warp 7
    grant(5); launch(7); dec(7, 0); step();
    chk("err_set", 64'(err), 64'd1);
    chk("err_elig", 64'(fetch_eligible), 64'h83);
    chk("err_active", 64'(active_cnt), 64'd3);
    launch_warp = 5'd5; #1;
    chk("warp5_idle", 64'(launch_ready), 64'd1);
    step();
    chk("err_sticky", 64'(err), 64'd1);

    // rdy low freezes everything
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      launch(5); grant(0); #1;
      chk("frz_launch_ready", 64'(launch_ready), 64'd0);
      @(posedge clk); #1;
      chk("frz_elig", 64'(fetch_eligible), 64'h83);
      chk("frz_active", 64'(active_cnt), 64'd3);
    end
    clr(); rdy = 1'b1;

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_elig", 64'(fetch_eligible), 64'h0);
    chk("arst_all_idle", 64'(all_idle), 64'd1);
    chk("arst_err", 64'(err), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // All 32 warps active
    for (int i = 0; i < 32; i++) begin
      launch(i); step();
    end
    chk("full_active", 64'(active_cnt), 64'd32);
    chk("full_elig", 64'(fetch_eligible), 64'hFFFF_FFFF);
    chk("full_all_idle", 64'(all_idle), 64'd0);
    chk("full_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gelato_warp_ctrl.md
Name: gelato_warp_ctrl

Overview:
- Per-warp lifecycle controller for the Gelato frontend. It tracks each warp's state: idle, ready, fetch in flight, branch wait, barrier, or exit.
- Drives the per-warp fetch-eligibility mask consumed by the PC table and fetch scheduler.
- Guarantees at most one outstanding fetch per warp and performs CTA-wide barrier release.
- Sits between the warp dispatcher (launch), the fetch scheduler (grant), decode (instruction kind) and the branch unit (resolve).

Parameters:
- WARP_NUM, 32, number of hardware warps (equals `WARP_MAX_NUM`).
- WARP_NUM_W, 5, width of warp index, log2(WARP_NUM).

Ports:
- clk  in  1  clock (already decided).
- rst_n  in  1  asynchronous, active-low reset (already decided).
- rdy  in  1  global enable; when low, all state is frozen and all inputs are ignored.
- launch_valid  in  1  dispatcher requests warp start.
- launch_warp  in  WARP_NUM_W  warp to start.
- launch_ready  out  1  combinational: rdy && state[launch_warp]==IDLE.
- grant_valid  in  1  fetch scheduler issued a PC for grant_warp.
- grant_warp  in  WARP_NUM_W  granted warp.
- dec_valid  in  1  decode reports a fetched instruction.
- dec_warp  in  WARP_NUM_W  warp of decoded instruction.
- dec_kind  in  2  0 normal, 1 branch, 2 barrier, 3 exit.
- br_valid  in  1  branch unit resolved a branch.
- br_warp  in  WARP_NUM_W  warp whose branch resolved.
- fetch_eligible  out  WARP_NUM  bit i = (state[i]==READY).
- active_cnt  out  WARP_NUM_W+1  number of non-IDLE warps.
- all_idle  out  1  active_cnt==0.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Per-warp state is a 3-bit register with encodings IDLE=0, READY=1, INFLIGHT=2, BRWAIT=3, BARRIER=4.
- Reset values:
  - all warps IDLE.
  - fetch_eligible=0, active_cnt=0, all_idle=1, err=0.
  - barrier release pending=0.
- All transitions take effect at the clk edge where rdy=1. Outputs are decoded from registered state only; no input-to-output comb path except launch_ready.
- Transitions:
  - IDLE->READY on launch_valid && launch_ready.
  - READY->INFLIGHT on grant_valid for that warp.
  - INFLIGHT->READY on dec kind 0.
  - INFLIGHT->BRWAIT on dec kind 1.
  - INFLIGHT->BARRIER on dec kind 2.
  - INFLIGHT->IDLE on dec kind 3.
  - BRWAIT->READY on br_valid.
  - BARRIER->READY on barrier release.
- Illegal events leave the state unchanged and set err; err clears only on reset. Illegal events are:
  - grant to a non-READY warp.
  - dec to a non-INFLIGHT warp.
  - br to a non-BRWAIT warp.
  - launch_valid while launch_ready=0 (stall, not an error, when rdy=1 and the warp is busy? No: this is an error only if the warp is non-IDLE; rdy=0 simply drops the launch).
- Simultaneous events on different warps all apply in the same cycle.
- The same warp targeted by two channels in one cycle is always illegal in at least one channel; the legal channel applies and err is set.
- Barrier release:
  - Computed from registered state: release_pend <= (active_cnt!=0) && (barrier_cnt==active_cnt) && (barrier_cnt!=0).
  - The cycle after release_pend=1, every BARRIER warp goes to READY and release_pend clears.
  - A warp entering BARRIER in cycle N is counted from cycle N+1, so release latency is 2 cycles after the last arrival.
  - An exit of the last non-barrier warp also satisfies the condition and triggers release.
  - No launch or dec can affect a BARRIER warp, so release never collides with another event for that warp.
- active_cnt and barrier_cnt are population counts of registered state, width WARP_NUM_W+1, so 32 warps are representable without wrap.
- rdy=0 mid-operation: no state change, release_pend held, outputs stable.
- Async reset mid-operation returns to reset values immediately; in-flight fetches are discarded by the frontend.

Test Plan:
- Launch warp 3 (pc ignored), then grant 3 -> fetch_eligible=0x8 after launch; 0x0 after grant; active_cnt=1, err=0.
- Warp 3 INFLIGHT, dec_kind=1, then br_valid warp 3 two cycles later -> state BRWAIT (eligible bit 0) until the br edge; eligible 0x8 on the next cycle.
- Launch warps 0,1,2; drive each through grant and dec_kind=2 with warp 2 last at cycle N -> release_pend at N+1; fetch_eligible=0x7 at N+2.
- Warps 0,1 in BARRIER, warp 2 INFLIGHT, dec_kind=3 for warp 2 -> active_cnt 3->2, release fires, eligible=0x3, warp 2 IDLE.
- Grant to IDLE warp 5; same-cycle launch and dec on warp 7 while IDLE -> err=1 sticky; launch applies, dec ignored, warp 5 unchanged.
- rdy=0 for 4 cycles with launch/grant driven, then rst_n pulse mid-run -> no state change while rdy=0; after reset eligible=0, all_idle=1, err=0.
